// File: rtl/bp_me_burst_arb.sv
// Purpose: round-robin arbiter merging N BedRock burst channels (header + data beats) onto one stream.
// Latency: zero cycles; headers and data beats pass combinationally from the selected or locked channel.
// Backpressure: downstream ready is routed only to the selected or locked channel. All other readies are 0.
//
// Ports:
//   clk_i, reset_n_i                 clock and asynchronous active-low reset
//   in_header_*/in_has_data_i        per-channel header handshake, packed with channel 0 in the LSBs
//   in_data_*/in_last_i              per-channel data-beat handshake, packed with channel 0 in the LSBs
//   out_header_*/out_has_data_o      merged header stream
//   out_data_*/out_last_o            merged data stream
//   grant_id_o                       channel that is currently selected (IDLE) or locked (DATA)
//   error_o                          sticky flag: a burst ran past max_beats_p
module bp_me_burst_arb #(
  parameter int num_chan_p     = 4,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64,
  parameter int max_beats_p    = 8,
  localparam int chan_id_width_lp  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int beat_cnt_width_lp = $clog2(max_beats_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_chan_p*header_width_p-1:0] in_header_i,
  input  logic [num_chan_p-1:0]                in_header_v_i,
  output logic [num_chan_p-1:0]                in_header_ready_and_o,
  input  logic [num_chan_p-1:0]                in_has_data_i,
  input  logic [num_chan_p*data_width_p-1:0]   in_data_i,
  input  logic [num_chan_p-1:0]                in_data_v_i,
  output logic [num_chan_p-1:0]                in_data_ready_and_o,
  input  logic [num_chan_p-1:0]                in_last_i,
  output logic [header_width_p-1:0]            out_header_o,
  output logic                                 out_header_v_o,
  output logic                                 out_has_data_o,
  input  logic                                 out_header_ready_and_i,
  output logic [data_width_p-1:0]              out_data_o,
  output logic                                 out_data_v_o,
  output logic                                 out_last_o,
  input  logic                                 out_data_ready_and_i,
  output logic [chan_id_width_lp-1:0]          grant_id_o,
  output logic                                 error_o
);

  typedef enum logic {e_idle, e_data} state_e;

  state_e                        state_r, state_n;
  logic [chan_id_width_lp-1:0]   rr_ptr_r, rr_ptr_n;
  logic [chan_id_width_lp-1:0]   lock_id_r, lock_id_n;
  logic [beat_cnt_width_lp-1:0]  beat_cnt_r, beat_cnt_n;
  logic                          error_r, error_n;

  logic [chan_id_width_lp-1:0]   sel_id;
  logic                          sel_v;
  logic [chan_id_width_lp:0]     cand;
  logic                          hdr_hs, data_hs;

  logic [header_width_p-1:0] hdr_arr  [num_chan_p];
  logic [data_width_p-1:0]   data_arr [num_chan_p];

  for (genvar g = 0; g < num_chan_p; g++) begin : g_unpack
    assign hdr_arr[g]  = in_header_i[g*header_width_p +: header_width_p];
    assign data_arr[g] = in_data_i[g*data_width_p +: data_width_p];
  end

  function automatic logic [chan_id_width_lp-1:0] inc_wrap(input logic [chan_id_width_lp-1:0] id);
    return (id == chan_id_width_lp'(num_chan_p - 1)) ? '0 : id + 1'b1;
  endfunction

  // Scan from rr_ptr upward with wrap. The first valid channel found wins.
  // With no channel valid, the selection falls back to rr_ptr.
  always_comb begin
    sel_id = rr_ptr_r;
    sel_v  = 1'b0;
    cand   = '0;
    for (int i = 0; i < num_chan_p; i++) begin
      cand = {1'b0, rr_ptr_r} + (chan_id_width_lp+1)'(i);
      if (cand >= (chan_id_width_lp+1)'(num_chan_p)) begin
        cand = cand - (chan_id_width_lp+1)'(num_chan_p);
      end
      if (!sel_v && in_header_v_i[cand[chan_id_width_lp-1:0]]) begin
        sel_v  = 1'b1;
        sel_id = cand[chan_id_width_lp-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      rr_ptr_r   <= '0;
      lock_id_r  <= '0;
      beat_cnt_r <= '0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      rr_ptr_r   <= rr_ptr_n;
      lock_id_r  <= lock_id_n;
      beat_cnt_r <= beat_cnt_n;
      error_r    <= error_n;
    end
  end

  // Next state and outputs. Every output is forced to 0 while reset is held,
  // so the outputs stay quiet whatever the inputs do during reset.
  always_comb begin
    state_n               = state_r;
    rr_ptr_n              = rr_ptr_r;
    lock_id_n             = lock_id_r;
    beat_cnt_n            = beat_cnt_r;
    error_n               = error_r;
    hdr_hs                = 1'b0;
    data_hs               = 1'b0;
    in_header_ready_and_o = '0;
    in_data_ready_and_o   = '0;
    out_header_o          = '0;
    out_header_v_o        = 1'b0;
    out_has_data_o        = 1'b0;
    out_data_o            = '0;
    out_data_v_o          = 1'b0;
    out_last_o            = 1'b0;
    grant_id_o            = '0;

    if (reset_n_i) begin
      case (state_r)
        e_idle: begin
          out_header_o                  = hdr_arr[sel_id];
          out_header_v_o                = sel_v;
          out_has_data_o                = in_has_data_i[sel_id];
          in_header_ready_and_o[sel_id] = out_header_ready_and_i;
          grant_id_o                    = sel_id;
          hdr_hs                        = sel_v & out_header_ready_and_i;
          if (hdr_hs) begin
            if (in_has_data_i[sel_id]) begin
              state_n    = e_data;
              lock_id_n  = sel_id;
              beat_cnt_n = '0;
            end else begin
              rr_ptr_n = inc_wrap(sel_id);
            end
          end
        end
        e_data: begin
          out_data_o                       = data_arr[lock_id_r];
          out_data_v_o                     = in_data_v_i[lock_id_r];
          out_last_o                       = in_last_i[lock_id_r];
          in_data_ready_and_o[lock_id_r]   = out_data_ready_and_i;
          grant_id_o                       = lock_id_r;
          data_hs                          = in_data_v_i[lock_id_r] & out_data_ready_and_i;
          if (data_hs) begin
            // The counter saturates, so an overlong burst cannot wrap it back to a legal value.
            if (beat_cnt_r != beat_cnt_width_lp'(max_beats_p)) begin
              beat_cnt_n = beat_cnt_r + 1'b1;
            end
            if (!in_last_i[lock_id_r] && beat_cnt_r == beat_cnt_width_lp'(max_beats_p - 1)) begin
              error_n = 1'b1;
            end
            if (in_last_i[lock_id_r]) begin
              state_n  = e_idle;
              rr_ptr_n = inc_wrap(lock_id_r);
            end
          end
        end
        default: state_n = e_idle;
      endcase
    end
  end

  assign error_o = error_r;

endmodule

// File: tb/tb_bp_me_burst_arb.sv
// Purpose: directed self-checking bench for bp_me_burst_arb with 4 channels and max 8 beats.
// Latency: inputs are driven 1ns after the rising edge, and outputs are checked a few ns later.
// Backpressure: the bench toggles downstream data ready and checks that no beat is lost.
module tb_bp_me_burst_arb;
  localparam int N  = 4;
  localparam int H  = 128;
  localparam int D  = 64;
  localparam int MB = 8;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N*H-1:0] in_header_i;
  logic [N-1:0]   in_header_v_i;
  logic [N-1:0]   in_header_ready_and_o;
  logic [N-1:0]   in_has_data_i;
  logic [N*D-1:0] in_data_i;
  logic [N-1:0]   in_data_v_i;
  logic [N-1:0]   in_data_ready_and_o;
  logic [N-1:0]   in_last_i;
  logic [H-1:0]   out_header_o;
  logic           out_header_v_o;
  logic           out_has_data_o;
  logic           out_header_ready_and_i;
  logic [D-1:0]   out_data_o;
  logic           out_data_v_o;
  logic           out_last_o;
  logic           out_data_ready_and_i;
  logic [1:0]     grant_id_o;
  logic           error_o;

  int tests_run    = 0;
  int tests_failed = 0;

  bp_me_burst_arb #(
    .num_chan_p(N), .header_width_p(H), .data_width_p(D), .max_beats_p(MB)
  ) dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .in_header_i           (in_header_i),
    .in_header_v_i         (in_header_v_i),
    .in_header_ready_and_o (in_header_ready_and_o),
    .in_has_data_i         (in_has_data_i),
    .in_data_i             (in_data_i),
    .in_data_v_i           (in_data_v_i),
    .in_data_ready_and_o   (in_data_ready_and_o),
    .in_last_i             (in_last_i),
    .out_header_o          (out_header_o),
    .out_header_v_o        (out_header_v_o),
    .out_has_data_o        (out_has_data_o),
    .out_header_ready_and_i(out_header_ready_and_i),
    .out_data_o            (out_data_o),
    .out_data_v_o          (out_data_v_o),
    .out_last_o            (out_last_o),
    .out_data_ready_and_i  (out_data_ready_and_i),
    .grant_id_o            (grant_id_o),
    .error_o               (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  logic [63:0] beats36 [4];
  logic [63:0] beats37 [3];
  logic [1:0]  rr_exp  [5];
  int          k;
  int          dut_hs;

  initial begin
    beats36 = '{64'hD2_0001, 64'hD2_0002, 64'hD2_0003, 64'hD2_0004};
    beats37 = '{64'hB1_00AA, 64'hB1_00BB, 64'hB1_00CC};
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n_i              = 1'b0;
    in_header_i            = '0;
    in_header_i[0*H +: H]  = 128'h1000;
    in_header_i[1*H +: H]  = 128'h1111;
    in_header_i[2*H +: H]  = 128'h2222;
    in_header_i[3*H +: H]  = 128'h3333;
    in_header_v_i          = 4'hF;
    in_has_data_i          = 4'h0;
    in_data_i              = '0;
    in_data_v_i            = 4'hF;
    in_last_i              = 4'h0;
    out_header_ready_and_i = 1'b1;
    out_data_ready_and_i   = 1'b1;

    // Reset holds every valid and ready output low, whatever the inputs do.
    #3;
    chk("rst_hdr_v",    out_header_v_o,        1'b0);
    chk("rst_hdr_rdy",  in_header_ready_and_o, 4'h0);
    chk("rst_data_rdy", in_data_ready_and_o,   4'h0);
    chk("rst_data_v",   out_data_v_o,          1'b0);
    chk("rst_grant",    grant_id_o,            2'd0);
    chk("rst_err",      error_o,               1'b0);
    @(negedge clk_i);
    reset_n_i     = 1'b1;
    in_header_v_i = 4'h0;
    in_data_v_i   = 4'h0;
    tick;

    // Channels 1 and 3 carry header-only messages. Expect grant 1, then grant 3.
    in_header_v_i = 4'b1010;
    settle;
    chk("t34_grant0", grant_id_o,            2'd1);
    chk("t34_hdr0",   out_header_o,          128'h1111);
    chk("t34_hv0",    out_header_v_o,        1'b1);
    chk("t34_rdy0",   in_header_ready_and_o, 4'b0010);
    tick;
    in_header_v_i = 4'b1000;
    settle;
    chk("t34_grant1", grant_id_o,            2'd3);
    chk("t34_hdr1",   out_header_o,          128'h3333);
    chk("t34_rdy1",   in_header_ready_and_o, 4'b1000);
    tick;

    // All channels stay valid. Expect the rotation 0,1,2,3,0.
    in_header_v_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      settle;
      chk($sformatf("t35_grant%0d", c), grant_id_o, rr_exp[c]);
      tick;
    end
    in_header_v_i = 4'h0;

    // The pointer is now at 1. Channel 2 starts a 4-beat burst while channel 0 waits.
    in_header_v_i = 4'b0101;
    in_has_data_i = 4'b0100;
    settle;
    chk("t36_grant",   grant_id_o,            2'd2);
    chk("t36_hasdata", out_has_data_o,        1'b1);
    chk("t36_rdy",     in_header_ready_and_o, 4'b0100);
    tick;
    in_header_v_i = 4'b0001;
    in_has_data_i = 4'b0000;
    in_data_v_i   = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      in_data_i[2*D +: D] = beats36[b];
      in_last_i           = (b == 3) ? 4'b0100 : 4'b0000;
      settle;
      chk($sformatf("t36_data%0d", b),   out_data_o,            beats36[b]);
      chk($sformatf("t36_dv%0d", b),     out_data_v_o,          1'b1);
      chk($sformatf("t36_last%0d", b),   out_last_o,            (b == 3) ? 1'b1 : 1'b0);
      chk($sformatf("t36_drdy%0d", b),   in_data_ready_and_o,   4'b0100);
      chk($sformatf("t36_hrdy%0d", b),   in_header_ready_and_o, 4'b0000);
      chk($sformatf("t36_hv%0d", b),     out_header_v_o,        1'b0);
      tick;
    end
    in_data_v_i = 4'h0;
    in_last_i   = 4'h0;
    settle;
    chk("t36_ch0_rdy", in_header_ready_and_o, 4'b0001);
    chk("t36_ch0_gnt", grant_id_o,            2'd0);
    chk("t36_idle_dv", out_data_v_o,          1'b0);
    tick;
    in_header_v_i = 4'h0;

    // The pointer is now at 1. Channel 1 sends a 3-beat burst while downstream ready toggles.
    in_header_v_i = 4'b0010;
    in_has_data_i = 4'b0010;
    settle;
    chk("t37_grant", grant_id_o, 2'd1);
    tick;
    in_header_v_i = 4'h0;
    in_has_data_i = 4'h0;
    k      = 0;
    dut_hs = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      out_data_ready_and_i = (c % 2 == 0);
      in_data_v_i          = 4'b0010;
      in_data_i[1*D +: D]  = beats37[k];
      in_last_i            = (k == 2) ? 4'b0010 : 4'b0000;
      settle;
      chk($sformatf("t37_data_c%0d", c), out_data_o,             beats37[k]);
      chk($sformatf("t37_rdy_c%0d", c),  in_data_ready_and_o[1], out_data_ready_and_i);
      if (in_data_ready_and_o[1]) dut_hs++;
      if (out_data_ready_and_i) k++;
      tick;
    end
    in_data_v_i          = 4'h0;
    in_last_i            = 4'h0;
    out_data_ready_and_i = 1'b1;
    settle;
    chk("t37_hs_count", dut_hs,       3);
    chk("t37_idle_dv",  out_data_v_o, 1'b0);
    chk("t37_rr",       grant_id_o,   2'd2);
    chk("t37_err",      error_o,      1'b0);

    // The pointer is now at 2. Channel 2 sends 9 beats. Error must rise after the 8th handshake.
    in_header_v_i = 4'b0100;
    in_has_data_i = 4'b0100;
    settle;
    tick;
    in_header_v_i = 4'h0;
    in_has_data_i = 4'h0;
    for (int n = 1; n <= 9; n++) begin
      in_data_v_i         = 4'b0100;
      in_data_i[2*D +: D] = 64'hE0 + 64'(n);
      in_last_i           = (n == 9) ? 4'b0100 : 4'b0000;
      settle;
      tick;
      chk($sformatf("t38_err_after%0d", n), error_o, (n >= 8) ? 1'b1 : 1'b0);
    end
    in_data_v_i = 4'h0;
    in_last_i   = 4'h0;
    tick;
    tick;
    tick;
    chk("t38_err_sticky", error_o, 1'b1);

    // The pointer is now at 3. Reset arrives during beat 2 of a channel 3 burst.
    in_header_v_i = 4'b1000;
    in_has_data_i = 4'b1000;
    settle;
    chk("t39_grant", grant_id_o, 2'd3);
    tick;
    in_header_v_i       = 4'b0001;
    in_has_data_i       = 4'b0000;
    in_data_v_i         = 4'b1000;
    in_data_i[3*D +: D] = 64'h3B01;
    settle;
    tick;
    in_data_i[3*D +: D] = 64'h3B02;
    settle;
    chk("t39_pre_dv", out_data_v_o, 1'b1);
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("t39_rst_dv",   out_data_v_o,          1'b0);
    chk("t39_rst_data", out_data_o,            64'h0);
    chk("t39_rst_drdy", in_data_ready_and_o,   4'h0);
    chk("t39_rst_hrdy", in_header_ready_and_o, 4'h0);
    chk("t39_rst_hv",   out_header_v_o,        1'b0);
    chk("t39_rst_gnt",  grant_id_o,            2'd0);
    chk("t39_rst_err",  error_o,               1'b0);
    #1;
    reset_n_i     = 1'b1;
    in_data_v_i   = 4'h0;
    in_header_v_i = 4'b1001;
    settle;
    chk("t39_post_gnt", grant_id_o,            2'd0);
    chk("t39_post_rdy", in_header_ready_and_o, 4'b0001);
    chk("t39_post_hv",  out_header_v_o,        1'b1);
    chk("t39_post_hdr", out_header_o,          128'h1000);
    chk("t39_post_dv",  out_data_v_o,          1'b0);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
